cfu_cmd_initiator: RTL and testbench
====================================

Name: cfu_cmd_initiator

Overview:
Hardware initiator for the CFU command/response protocol. It drives the CPU side of the Cfu MAC (SET_MODE / RESET_ACC / LOAD_UPPER / ACCUM opcodes) from a job descriptor and a stream of 64-bit operand pairs. It returns the final 32-bit accumulator on a result handshake. Used to run dot-product jobs and to bench the Cfu without a CPU model; it connects port-for-port to the Cfu cmd_*/rsp_* interface.

Parameters:
CNT_W, 16, width of the operand-pair count.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  job launch pulse; sampled only in IDLE
start_mode  in  1  0 = 8-bit lanes, 1 = 4-bit lanes
start_count  in  CNT_W  number of 64-bit operand pairs in the job
busy  out  1  high in every state except IDLE
opnd_valid  in  1  operand pair available
opnd_ready  out  1  initiator accepts an operand pair
opnd_a  in  64  packed activations
opnd_b  in  64  packed weights
result_valid  out  1  job result available
result_ready  in  1  result consumer ready
result_data  out  32  final accumulator value
cmd_valid  out  1  CFU command valid
cmd_ready  in  1  CFU command ready
cmd_payload_function_id  out  10  [2:0] opcode, [3] mode bit, [9:4] zero
cmd_payload_inputs_0  out  32  operand A word
cmd_payload_inputs_1  out  32  operand B word
rsp_valid  in  1  CFU response valid
rsp_ready  out  1  initiator accepts the response
rsp_payload_outputs_0  in  32  CFU response data
proto_err  out  1  sticky; set when rsp_valid is seen outside RSP_WAIT

Behaviour:
- Reset values: all outputs 0. State is IDLE. Internal registers (mode, remaining count, operand latches, accumulator copy) are 0.
- Opcodes: SET_MODE=0, RESET_ACC=1, LOAD_UPPER=2, ACCUM=3. The function_id mode bit is meaningful only for SET_MODE and is driven 0 for all other opcodes.
- States: IDLE, SET_MODE, CLR_ACC, FETCH, LOAD_UP, ACCUM, RSP_WAIT, DONE. RSP_WAIT holds a registered return state.
- IDLE: on start, latch start_mode and start_count, then go to SET_MODE. When busy, start is ignored in all states, including DONE.
- Issue states (SET_MODE, CLR_ACC, LOAD_UP, ACCUM):
  - cmd_valid=1, with payload driven from registers.
  - Payload is stable while cmd_valid && !cmd_ready.
  - On cmd_valid && cmd_ready, go to RSP_WAIT in the next cycle with cmd_valid=0.
  - Only one command is outstanding at a time.
- RSP_WAIT: rsp_ready=1. On rsp_valid, capture rsp_payload_outputs_0 into acc and go to the return state:
  - after SET_MODE: go to CLR_ACC.
  - after CLR_ACC: go to DONE if remaining==0, else FETCH.
  - after LOAD_UP: go to ACCUM.
  - after ACCUM: decrement remaining; go to DONE if it reaches 0, else FETCH.
- rsp_ready=0 outside RSP_WAIT. A response seen there sets proto_err; proto_err clears only on reset.
- SET_MODE payload: function_id={6'b0, mode, 3'd0}; inputs are 0.
- CLR_ACC payload: function_id=1; inputs are 0.
- FETCH: opnd_ready=1. On opnd_valid, latch opnd_a and opnd_b, then go to LOAD_UP. There is no combinational path from opnd_valid to opnd_ready.
- LOAD_UP payload: inputs_0=a[63:32], inputs_1=b[63:32].
- ACCUM payload: inputs_0=a[31:0], inputs_1=b[31:0].
- DONE: result_valid=1 and result_data=acc, both held until result_ready; then go to IDLE.
- count==0: the job is SET_MODE then CLR_ACC, and the result is the RESET_ACC response (0).
- Latency against a zero-wait Cfu:
  - SET_MODE + CLR_ACC: 4 cycles.
  - Each pair: 5 cycles (FETCH, LOAD_UP, RSP_WAIT, ACCUM, RSP_WAIT).
  - DONE: 1 cycle.
- Reset mid-job returns to IDLE immediately, drops cmd_valid, discards operands, and does not assert result_valid. The Cfu shares the same reset.
- Accumulation width is 32 bits and wraps modulo 2^32 inside the Cfu. The initiator never sums; it only copies the response.

Decomposition:
- Shared package cfu_pkg holds:
  - opcode constants OP_SET_MODE, OP_RESET_ACC, OP_LOAD_UPPER, OP_ACCUM;
  - function_id field positions (OPC_LSB=0, OPC_W=3, MODE_BIT=3);
  - the state enum type.
- The block is a single module with no sub-module. The command encoder is a small combinational function in the package.

Test Plan:
- mode0, count1, a=64'h0101010101010101, b=64'h0202020202020202, ideal Cfu:
  - command order is 0 (fid=0), 1, 2, 3;
  - result_data=16;
  - result_valid is asserted 10 cycles after start.
- mode1 (SET_MODE fid=10'h008), count2, both pairs a=64'h1111111111111111, b=64'h2222222222222222 -> result_data=64.
- count0, mode0 -> commands are SET_MODE then RESET_ACC only; result_data=0; opnd_ready is never asserted.
- Backpressure on cmd_ready (low for 3 cycles per command), rsp_valid delayed, opnd_valid gaps, result_ready low 5 cycles:
  - payload is stable while cmd_valid is held;
  - the result equals the ideal-case result;
  - start pulses while busy are ignored.
- Reset asserted in RSP_WAIT of the 2nd pair:
  - cmd_valid=0 and busy=0 in the next cycle;
  - a new job count1 (0x01 bytes × 0x03 bytes, mode0) returns 24.
- Injected spurious rsp_valid while in FETCH -> proto_err=1, held until reset; the job still completes.

Source files
------------

// File: rtl/cfu_pkg.sv
// cfu_pkg: CFU opcodes, function_id field layout, initiator states and command encoder.
package cfu_pkg;

   localparam logic [2:0] OP_SET_MODE   = 3'd0;
   localparam logic [2:0] OP_RESET_ACC  = 3'd1;
   localparam logic [2:0] OP_LOAD_UPPER = 3'd2;
   localparam logic [2:0] OP_ACCUM      = 3'd3;

   localparam int OPC_LSB  = 0;
   localparam int OPC_W    = 3;
   localparam int MODE_BIT = 3;

   typedef enum logic [2:0] {
      ST_IDLE, ST_SET_MODE, ST_CLR_ACC, ST_FETCH,
      ST_LOAD_UP, ST_ACCUM, ST_RSP_WAIT, ST_DONE
   } state_e;

   function automatic logic is_issue(input state_e s);
      return s inside {ST_SET_MODE, ST_CLR_ACC, ST_LOAD_UP, ST_ACCUM};
   endfunction

   // Mode bit only rides on SET_MODE; non-issue states encode to zero.
   function automatic logic [9:0] enc_fid(input state_e s, input logic mode);
      logic [9:0] fid;
      fid = '0;
      fid[OPC_LSB +: OPC_W] = (s == ST_SET_MODE) ? OP_SET_MODE :
                              (s == ST_CLR_ACC)  ? OP_RESET_ACC :
                              (s == ST_LOAD_UP)  ? OP_LOAD_UPPER : OP_ACCUM;
      fid[MODE_BIT] = (s == ST_SET_MODE) && mode;
      return is_issue(s) ? fid : '0;
   endfunction

endpackage

// File: rtl/cfu_cmd_initiator.sv
// cfu_cmd_initiator: runs a dot-product job on the Cfu via its cmd/rsp handshake
// and returns the final accumulator on a result handshake.
module cfu_cmd_initiator
   import cfu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             start_mode,
   input  logic [CNT_W-1:0] start_count,
   output logic             busy,
   input  logic             opnd_valid,
   output logic             opnd_ready,
   input  logic [63:0]      opnd_a,
   input  logic [63:0]      opnd_b,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [31:0]      result_data,
   output logic             cmd_valid,
   input  logic             cmd_ready,
   output logic [9:0]       cmd_payload_function_id,
   output logic [31:0]      cmd_payload_inputs_0,
   output logic [31:0]      cmd_payload_inputs_1,
   input  logic             rsp_valid,
   output logic             rsp_ready,
   input  logic [31:0]      rsp_payload_outputs_0,
   output logic             proto_err
);

   state_e           state_q, state_d, ret_q, ret_d;
   logic             mode_q, mode_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [63:0]      a_q, a_d, b_q, b_d;
   logic [31:0]      acc_q, acc_d;
   logic [31:0]      in0_q, in0_d, in1_q, in1_d;
   logic [9:0]       fid_q, fid_d;
   logic             cmd_valid_q, opnd_ready_q, rsp_ready_q, result_valid_q, busy_q, proto_q;

   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      mode_d  = mode_q;
      rem_d   = rem_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      unique case (state_q)
         ST_IDLE: if (start) begin
            mode_d  = start_mode;
            rem_d   = start_count;
            state_d = ST_SET_MODE;
         end
         ST_SET_MODE, ST_CLR_ACC, ST_LOAD_UP, ST_ACCUM: if (cmd_ready) begin
            ret_d   = state_q;
            state_d = ST_RSP_WAIT;
         end
         ST_FETCH: if (opnd_valid) begin
            a_d     = opnd_a;
            b_d     = opnd_b;
            state_d = ST_LOAD_UP;
         end
         ST_RSP_WAIT: if (rsp_valid) begin
            acc_d   = rsp_payload_outputs_0;
            rem_d   = (ret_q == ST_ACCUM) ? rem_q - CNT_W'(1) : rem_q;
            state_d = (ret_q == ST_SET_MODE) ? ST_CLR_ACC :
                      (ret_q == ST_LOAD_UP)  ? ST_ACCUM :
                      (rem_d == '0)          ? ST_DONE : ST_FETCH;
         end
         ST_DONE: if (result_ready) state_d = ST_IDLE;
         default: ;
      endcase
      // Payload is a pure function of the next state and latched operands, so it holds under backpressure.
      fid_d = enc_fid(state_d, mode_d);
      in0_d = (state_d == ST_LOAD_UP) ? a_d[63:32] : (state_d == ST_ACCUM) ? a_d[31:0] : '0;
      in1_d = (state_d == ST_LOAD_UP) ? b_d[63:32] : (state_d == ST_ACCUM) ? b_d[31:0] : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         ret_q          <= ST_IDLE;
         mode_q         <= 1'b0;
         rem_q          <= '0;
         a_q            <= '0;
         b_q            <= '0;
         acc_q          <= '0;
         in0_q          <= '0;
         in1_q          <= '0;
         fid_q          <= '0;
         cmd_valid_q    <= 1'b0;
         opnd_ready_q   <= 1'b0;
         rsp_ready_q    <= 1'b0;
         result_valid_q <= 1'b0;
         busy_q         <= 1'b0;
         proto_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         ret_q          <= ret_d;
         mode_q         <= mode_d;
         rem_q          <= rem_d;
         a_q            <= a_d;
         b_q            <= b_d;
         acc_q          <= acc_d;
         in0_q          <= in0_d;
         in1_q          <= in1_d;
         fid_q          <= fid_d;
         cmd_valid_q    <= is_issue(state_d);
         opnd_ready_q   <= state_d == ST_FETCH;
         rsp_ready_q    <= state_d == ST_RSP_WAIT;
         result_valid_q <= state_d == ST_DONE;
         busy_q         <= state_d != ST_IDLE;
         proto_q        <= proto_q | (rsp_valid && state_q != ST_RSP_WAIT);
      end
   end

   assign busy                    = busy_q;
   assign opnd_ready              = opnd_ready_q;
   assign result_valid            = result_valid_q;
   assign result_data             = acc_q;
   assign cmd_valid               = cmd_valid_q;
   assign cmd_payload_function_id = fid_q;
   assign cmd_payload_inputs_0    = in0_q;
   assign cmd_payload_inputs_1    = in1_q;
   assign rsp_ready               = rsp_ready_q;
   assign proto_err               = proto_q;

endmodule

// File: tb/tb_cfu_cmd_initiator.sv
// tb_cfu_cmd_initiator: drives jobs against a behavioural Cfu and scoreboards
// every command and result the initiator produces.
module tb_cfu_cmd_initiator;

   logic        clk = 1'b0;
   logic        reset, start, start_mode;
   logic [15:0] start_count;
   logic        busy, opnd_valid, opnd_ready;
   logic [63:0] opnd_a, opnd_b;
   logic        result_valid, result_ready;
   logic [31:0] result_data;
   logic        cmd_valid, cmd_ready;
   logic [9:0]  cmd_payload_function_id;
   logic [31:0] cmd_payload_inputs_0, cmd_payload_inputs_1;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_payload_outputs_0;
   logic        proto_err;

   cfu_cmd_initiator #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset), .start(start), .start_mode(start_mode), .start_count(start_count),
      .busy(busy), .opnd_valid(opnd_valid), .opnd_ready(opnd_ready), .opnd_a(opnd_a), .opnd_b(opnd_b),
      .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_payload_function_id(cmd_payload_function_id),
      .cmd_payload_inputs_0(cmd_payload_inputs_0), .cmd_payload_inputs_1(cmd_payload_inputs_1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_payload_outputs_0),
      .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int lat;
   logic [73:0]  exp_cmd[$];
   logic [31:0]  exp_res[$];
   logic [127:0] opq[$];
   logic [73:0]  cur;
   assign cur = {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1};

   int cmd_bp = 0, rsp_dly = 0, op_gap = 0, res_hold = 0;
   int bp_cnt = 0, rsp_cnt = 0, gap_cnt = 0, rr_cnt = 0, n_load = 0;
   bit pend = 0, inject_req = 0, saw_or = 0;
   bit cmd_fire_q = 0, rsp_fire_q = 0, opnd_fire_q = 0, res_fire_q = 0, hold_q = 0;
   logic [73:0] fired, held;
   logic [31:0] ua, ub, cacc, rsp_d;
   logic        cmode;

   task automatic chk(input string nm, input logic [73:0] act, input logic [73:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] dot(input logic [31:0] x, input logic [31:0] y, input logic m);
      logic [31:0] s;
      s = '0;
      for (int i = 0; i < 8; i++) if (m) s += 32'(x[4*i +: 4]) * 32'(y[4*i +: 4]);
      for (int i = 0; i < 4; i++) if (!m) s += 32'(x[8*i +: 8]) * 32'(y[8*i +: 8]);
      return s;
   endfunction

   task automatic cfu_exec(input logic [73:0] c);
      case (c[66:64])
         3'd0: begin cmode = c[67]; rsp_d = '0; end
         3'd1: begin cacc = '0; rsp_d = '0; end
         3'd2: begin ua = c[63:32]; ub = c[31:0]; rsp_d = cacc; end
         default: begin cacc = cacc + dot(ua, ub, cmode) + dot(c[63:32], c[31:0], cmode); rsp_d = cacc; end
      endcase
   endtask

   // Behavioural Cfu, operand source and result sink; acts 1 time unit after the falling edge.
   initial begin : agent
      forever begin
         @(negedge clk);
         #1;
         if (reset) begin
            pend = 0; cacc = '0; cmode = 1'b0; ua = '0; ub = '0; rsp_d = '0;
            rsp_valid = 1'b0; rsp_payload_outputs_0 = '0; cmd_ready = 1'b0;
            opnd_valid = 1'b0; opnd_a = '0; opnd_b = '0; result_ready = 1'b0;
            bp_cnt = 0; rsp_cnt = 0; gap_cnt = 0; rr_cnt = 0;
         end else begin
            if (rsp_fire_q) pend = 0;
            if (cmd_fire_q) begin cfu_exec(fired); pend = 1; rsp_cnt = 0; end
            rsp_valid = pend && rsp_cnt >= rsp_dly;
            if (pend && !rsp_valid) rsp_cnt++;
            rsp_payload_outputs_0 = rsp_d;
            if (inject_req && opnd_ready && !pend) begin
               rsp_valid = 1'b1;
               rsp_payload_outputs_0 = 32'hDEAD_BEEF;
               inject_req = 0;
            end
            if (opnd_fire_q) begin void'(opq.pop_front()); gap_cnt = 0; end
            if (opnd_ready) saw_or = 1;
            opnd_valid = opq.size() > 0 && gap_cnt >= op_gap;
            if (opnd_ready && !opnd_valid) gap_cnt++;
            {opnd_a, opnd_b} = opq.size() > 0 ? opq[0] : 128'd0;
            if (cmd_fire_q) bp_cnt = 0;
            cmd_ready = cmd_valid && bp_cnt >= cmd_bp;
            if (cmd_valid && !cmd_ready) bp_cnt++;
            if (res_fire_q) rr_cnt = 0;
            result_ready = result_valid && rr_cnt >= res_hold;
            if (result_valid && !result_ready) rr_cnt++;
         end
         cmd_fire_q  = !reset && cmd_valid && cmd_ready;
         rsp_fire_q  = !reset && rsp_valid && rsp_ready;
         opnd_fire_q = !reset && opnd_valid && opnd_ready;
         res_fire_q  = !reset && result_valid && result_ready;
         if (cmd_fire_q) begin
            fired = cur;
            if (cur[66:64] == 3'd2) n_load++;
         end
      end
   end

   // Scoreboard monitor: compares every fired command and result against the queues.
   initial begin : monitor
      forever begin
         @(negedge clk);
         #2;
         if (!reset && cmd_valid && cmd_ready) begin
            if (exp_cmd.size() == 0) begin
               checks++; errors++;
               $display("FAIL cmd_unexpected got %h want none", cur);
            end else chk("cmd", cur, exp_cmd.pop_front());
         end
         if (!reset && result_valid && result_ready) begin
            if (exp_res.size() == 0) begin
               checks++; errors++;
               $display("FAIL result_unexpected got %h want none", result_data);
            end else chk("result", 74'(result_data), 74'(exp_res.pop_front()));
         end
         if (hold_q && !reset && cmd_valid) chk("cmd_stable", cur, held);
         hold_q = !reset && cmd_valid && !cmd_ready;
         held = cur;
      end
   end

   task automatic begin_job(input logic m, input logic [31:0] res);
      exp_cmd.push_back({(m ? 10'h008 : 10'h000), 64'd0});
      exp_cmd.push_back({10'h001, 64'd0});
      exp_res.push_back(res);
   endtask

   task automatic pair(input logic [63:0] a, input logic [63:0] b);
      opq.push_back({a, b});
      exp_cmd.push_back({10'h002, a[63:32], b[63:32]});
      exp_cmd.push_back({10'h003, a[31:0], b[31:0]});
   endtask

   task automatic flush();
      exp_cmd.delete();
      exp_res.delete();
      opq.delete();
   endtask

   task automatic run(input logic m, input logic [15:0] n, input bit stray, input int lim, output int first);
      int cyc;
      cyc = 0;
      first = 0;
      @(negedge clk);
      start_mode = m; start_count = n; start = 1'b1;
      while ((exp_res.size() > 0 || exp_cmd.size() > 0) && cyc < lim) begin
         @(negedge clk);
         cyc++;
         if (result_valid && first == 0) first = cyc;
         start = stray && (cyc % 6 == 3 || result_valid);
         start_count = 16'd5;
      end
      start = 1'b0;
      if (cyc >= lim) begin
         checks++; errors++;
         $display("FAIL job_timeout got %0d cycles want done", cyc);
         flush();
      end
   endtask

   task automatic idle_chk(input string nm, input logic pe);
      repeat (3) @(negedge clk);
      chk({nm, "_busy"}, 74'(busy), 74'(0));
      chk({nm, "_cmd_valid"}, 74'(cmd_valid), 74'(0));
      chk({nm, "_proto_err"}, 74'(proto_err), 74'(pe));
   endtask

   initial begin : main
      int cyc;
      reset = 1'b1; start = 1'b0; start_mode = 1'b0; start_count = '0;
      opnd_valid = 1'b0; opnd_a = '0; opnd_b = '0; result_ready = 1'b0;
      cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_payload_outputs_0 = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 74'(busy), 74'(0));
      chk("rst_cmd_valid", 74'(cmd_valid), 74'(0));
      chk("rst_payload", cur, 74'(0));
      chk("rst_opnd_ready", 74'(opnd_ready), 74'(0));
      chk("rst_rsp_ready", 74'(rsp_ready), 74'(0));
      chk("rst_result_valid", 74'(result_valid), 74'(0));
      chk("rst_result_data", 74'(result_data), 74'(0));
      chk("rst_proto_err", 74'(proto_err), 74'(0));
      reset = 1'b0;

      // 8-bit lanes, one pair: 8 x (1*2) = 16, result 10 cycles after start
      begin_job(1'b0, 32'd16);
      pair(64'h0101010101010101, 64'h0202020202020202);
      run(1'b0, 16'd1, 1'b0, 200, lat);
      chk("t1_latency", 74'(lat), 74'(10));
      idle_chk("t1", 1'b0);

      // 4-bit lanes, two pairs: 2 x 16 x (1*2) = 64
      begin_job(1'b1, 32'd64);
      pair(64'h1111111111111111, 64'h2222222222222222);
      pair(64'h1111111111111111, 64'h2222222222222222);
      run(1'b1, 16'd2, 1'b0, 200, lat);
      idle_chk("t2", 1'b0);

      // empty job: SET_MODE, RESET_ACC, result 0, no operand fetch
      saw_or = 0;
      begin_job(1'b0, 32'd0);
      run(1'b0, 16'd0, 1'b0, 200, lat);
      chk("t3_no_opnd_ready", 74'(saw_or), 74'(0));
      idle_chk("t3", 1'b0);

      // backpressure everywhere plus stray starts: (1+..+8)*1 + 8*(1*4) = 36 + 32 = 68
      cmd_bp = 3; rsp_dly = 2; op_gap = 2; res_hold = 5;
      begin_job(1'b0, 32'd68);
      pair(64'h0102030405060708, 64'h0101010101010101);
      pair(64'h0101010101010101, 64'h0404040404040404);
      run(1'b0, 16'd2, 1'b1, 500, lat);
      idle_chk("t4", 1'b0);
      cmd_bp = 0; rsp_dly = 0; op_gap = 0; res_hold = 0;

      // reset while waiting for the 2nd pair's LOAD_UPPER response
      n_load = 0;
      begin_job(1'b0, 32'd0);
      pair(64'h0101010101010101, 64'h0202020202020202);
      pair(64'h0101010101010101, 64'h0202020202020202);
      pair(64'h0101010101010101, 64'h0202020202020202);
      @(negedge clk);
      start_mode = 1'b0; start_count = 16'd3; start = 1'b1;
      cyc = 0;
      while (n_load < 2 && cyc < 200) begin
         @(negedge clk);
         start = 1'b0;
         cyc++;
      end
      if (cyc >= 200) begin
         checks++; errors++;
         $display("FAIL t5_reach_pair2 got %0d cycles want done", cyc);
      end
      chk("t5_in_rsp_wait", 74'(rsp_ready), 74'(1));
      reset = 1'b1;
      flush();
      @(negedge clk);
      chk("t5_cmd_valid", 74'(cmd_valid), 74'(0));
      chk("t5_busy", 74'(busy), 74'(0));
      chk("t5_result_valid", 74'(result_valid), 74'(0));
      chk("t5_result_data", 74'(result_data), 74'(0));
      reset = 1'b0;
      begin_job(1'b0, 32'd24);
      pair(64'h0101010101010101, 64'h0303030303030303);
      run(1'b0, 16'd1, 1'b0, 200, lat);
      idle_chk("t5", 1'b0);

      // spurious response during FETCH: sticky proto_err, job still completes
      inject_req = 1; op_gap = 2;
      begin_job(1'b0, 32'd16);
      pair(64'h0101010101010101, 64'h0202020202020202);
      run(1'b0, 16'd1, 1'b0, 200, lat);
      chk("t6_injected", 74'(inject_req), 74'(0));
      idle_chk("t6", 1'b1);
      op_gap = 0;
      reset = 1'b1;
      @(negedge clk);
      chk("t6_proto_cleared", 74'(proto_err), 74'(0));
      reset = 1'b0;
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
